// File: rtl/man_receiver.sv
// man_receiver: Manchester line decoder with preamble/SFD hunt, LSB-first byte assembly and frame-end detection
module man_receiver #(
  parameter int BIT_CLKS = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       write,
  output logic       cardet,
  output logic       eof,
  output logic       error,
  output logic [7:0] errcnt
);
  localparam int PW = $clog2(3 * BIT_CLKS / 2 + 1);
  localparam logic [PW-1:0] PH_MAX = PW'(3 * BIT_CLKS / 2);
  localparam logic [PW-1:0] PH_MIN = PW'(3 * BIT_CLKS / 4);
  localparam logic [7:0] SFD = 8'hD0;
  typedef enum logic [1:0] {IDLE, HUNT, RECEIVE} state_t;
  state_t state_q;
  logic sync1_q, sync2_q, prev_q, edg_q, full_q;
  logic [PW-1:0] ph_q, ph_d;
  logic [7:0] sreg_q, sreg_d, data_q, errcnt_q;
  logic [2:0] bcnt_q;
  logic write_q, cardet_q, eof_q, error_q;
  logic acc, tmo;
  // edg_q is registered so every edge reaches the FSM with the same fixed delay; prev_q is then the post-edge level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      edg_q   <= 1'b0;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edg_q   <= sync2_q ^ prev_q;
    end
  end
  always_comb begin
    ph_d   = (ph_q == PH_MAX) ? ph_q : ph_q + PW'(1);
    sreg_d = {prev_q, sreg_q[7:1]};
    acc    = edg_q && (ph_q >= PH_MIN);
    tmo    = !acc && (ph_d == PH_MAX);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      sreg_q   <= '0;
      bcnt_q   <= '0;
      full_q   <= 1'b0;
      data_q   <= '0;
      write_q  <= 1'b0;
      cardet_q <= 1'b0;
      eof_q    <= 1'b0;
      error_q  <= 1'b0;
      errcnt_q <= '0;
    end else begin
      write_q <= 1'b0;
      eof_q   <= 1'b0;
      error_q <= 1'b0;
      ph_q    <= ph_d;
      case (state_q)
        IDLE: if (edg_q && prev_q) begin
          state_q  <= HUNT;
          cardet_q <= 1'b1;
          sreg_q   <= sreg_d;
          ph_q     <= '0;
          bcnt_q   <= 3'd1;
          full_q   <= 1'b0;
        end
        HUNT: if (acc) begin
          sreg_q <= sreg_d;
          ph_q   <= '0;
          bcnt_q <= bcnt_q + 3'd1;
          full_q <= full_q || (&bcnt_q);
          if ((full_q || (&bcnt_q)) && sreg_d == SFD) begin
            state_q <= RECEIVE;
            bcnt_q  <= '0;
          end
        end else if (tmo) begin
          state_q  <= IDLE;
          cardet_q <= 1'b0;
        end
        RECEIVE: if (acc) begin
          sreg_q <= sreg_d;
          ph_q   <= '0;
          bcnt_q <= bcnt_q + 3'd1;
          if (&bcnt_q) begin
            data_q  <= sreg_d;
            write_q <= 1'b1;
          end
        end else if (tmo) begin
          state_q  <= IDLE;
          cardet_q <= 1'b0;
          eof_q    <= bcnt_q == 3'd0;
          error_q  <= bcnt_q != 3'd0;
          if (bcnt_q != 3'd0 && !(&errcnt_q)) errcnt_q <= errcnt_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign data   = data_q;
  assign write  = write_q;
  assign cardet = cardet_q;
  assign eof    = eof_q;
  assign error  = error_q;
  assign errcnt = errcnt_q;
endmodule

// File: doc/man_receiver.md
MAN_RECEIVER -- requirements
Module: man_receiver

Interface
REQ-001 SHALL have parameter BIT_CLKS, default 10416, giving clk cycles per Manchester bit period (100 MHz / 9600 baud).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rxd  input  1  asynchronous Manchester serial line; idle level high.
REQ-005 SHALL have port data  output  8  last assembled byte.
REQ-006 SHALL have port write  output  1  one-cycle strobe, data valid.
REQ-007 SHALL have port cardet  output  1  carrier/frame in progress.
REQ-008 SHALL have port eof  output  1  one-cycle strobe, frame ended cleanly.
REQ-009 SHALL have port error  output  1  one-cycle strobe, frame ended mid-byte.
REQ-010 SHALL have port errcnt  output  8  count of error strobes since reset.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; all decoding uses the synchronized level and a registered previous level for edge detection.
REQ-012 SHALL decode line code: bit 1 = low first half, high second half (rising mid-bit edge); bit 0 = falling mid-bit edge; decoded bit = level after the mid-bit edge.
REQ-013 SHALL keep phase counter ph, zeroed on every accepted mid-bit edge, incrementing each clk otherwise, saturating at 3*BIT_CLKS/2.
REQ-014 SHALL accept an edge as mid-bit only when ph >= 3*BIT_CLKS/4; earlier edges (bit-boundary edges) are ignored.
REQ-015 SHALL assemble bits LSB first: sreg <= {bit, sreg[7:1]}, with 3-bit bit counter bcnt.
REQ-016 SHALL implement states IDLE, HUNT, RECEIVE.
REQ-017 IDLE: falling edges ignored; a rising edge -> HUNT, shift in bit 1, ph=0, bcnt=1.
REQ-018 HUNT: shift each accepted bit; when >= 8 bits shifted since entry and sreg == 8'hD0 (SFD) -> RECEIVE, bcnt=0; preamble bytes 8'h55 never match.
REQ-019 RECEIVE: on 8th bit (bcnt wraps 7->0), data <= assembled byte, write high for exactly one clk.
REQ-020 Timeout: ph reaching 3*BIT_CLKS/2 SHALL end the frame -> IDLE in that cycle.
REQ-021 Timeout in HUNT: -> IDLE, no eof, no error.
REQ-022 Timeout in RECEIVE with bcnt == 0: eof high one clk; with bcnt != 0: error high one clk, partial byte discarded, no write.
REQ-023 errcnt SHALL increment on each error strobe and saturate at 8'hFF.
REQ-024 cardet SHALL be 1 exactly while state is HUNT or RECEIVE.
REQ-025 Latency: write SHALL rise exactly 4 clk cycles after the rxd transition carrying bit 7, identical for every byte.
REQ-026 data SHALL hold its value until the next write; write, eof, error mutually exclusive in any cycle.
REQ-027 SHALL tolerate bit-period jitter of +/-BIT_CLKS/8 per bit without bit loss.

Reset
REQ-028 On rst: state IDLE, data=8'h00, write=0, cardet=0, eof=0, error=0, errcnt=0, sreg/bcnt/ph=0, synchronizer flops=1.
REQ-029 rst mid-frame SHALL abort immediately with no write/eof/error strobe; the next frame SHALL decode normally.

Verification (BIT_CLKS=16)
REQ-030 Frame 55 55 D0 A5 then idle high -> single write, data=8'hA5, cardet falls with eof pulse 24 clks after last mid-bit edge, errcnt=0.
REQ-031 Preamble 55 55 55 then idle -> cardet 1 then 0, no write, no eof, no error.
REQ-032 55 D0 + 4 bits then idle -> error pulse, errcnt=1, no write, data unchanged.
REQ-033 Assert rst during 3rd data bit of 55 D0 3C -> all outputs 0 next cycle; following frame 55 D0 7E -> write with data=8'h7E.
REQ-034 Frame 55 D0 00 FF with bit periods alternating 14/18 clks -> writes 8'h00 then 8'hFF, eof.
REQ-035 260 truncated frames -> errcnt=8'hFF, no wrap.
